// File: rtl/wb_pipe_reg.sv
// Write-back pipeline register: multi-lane capture with flush/bubble/hold
// control, same-group write-conflict sanitising and two performance counters.
module wb_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LANES  = 2,
    parameter int unsigned STAGE  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    input  logic [LANES*ADDR_W-1:0]  mem_rd,
    input  logic [LANES*DATA_W-1:0]  mem_wdata,
    input  logic [LANES-1:0]         mem_wreg,
    output logic [LANES*ADDR_W-1:0]  wb_rd,
    output logic [LANES*DATA_W-1:0]  wb_wdata,
    output logic [LANES-1:0]         wb_wreg,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_ZERO    = 2'd2
    } act_e;

    // Extra zero bit lets STAGE=5 see a never-held next stage.
    logic [6:0] stall_ext;
    logic       this_held;
    logic       next_held;
    act_e       act;

    logic [LANES*ADDR_W-1:0] rd_q,     rd_d;
    logic [LANES*DATA_W-1:0] wdata_q,  wdata_d;
    logic [LANES-1:0]        wreg_q,   wreg_d;
    logic [CNT_W-1:0]        retire_q, retire_d;
    logic [CNT_W-1:0]        bubble_q, bubble_d;

    logic [LANES-1:0]        wreg_san;
    logic [CNT_W-1:0]        san_pop;

    assign stall_ext = {1'b0, stall};
    assign this_held = stall_ext[STAGE];
    assign next_held = stall_ext[STAGE+1];

    // Select one action per edge: flush beats bubble beats hold beats capture.
    always_comb begin
        act = ACT_CAPTURE;
        if (flush) begin
            act = ACT_ZERO;
        end else if (this_held && !next_held) begin
            act = ACT_ZERO;
        end else if (this_held) begin
            act = ACT_HOLD;
        end
    end

    // Drop writes to x0 and writes shadowed by a younger lane to the same register.
    always_comb begin
        logic [ADDR_W-1:0] rd_i;
        logic              keep;
        wreg_san = '0;
        san_pop  = '0;
        rd_i     = '0;
        keep     = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            rd_i = mem_rd[i*ADDR_W +: ADDR_W];
            keep = mem_wreg[i] && (rd_i != '0);
            for (int j = i + 1; j < int'(LANES); j++) begin
                if (mem_wreg[j] && (mem_rd[j*ADDR_W +: ADDR_W] == rd_i)) begin
                    keep = 1'b0;
                end
            end
            wreg_san[i] = keep;
            san_pop     = CNT_W'(san_pop + CNT_W'(keep));
        end
    end

    // Next-state for pipeline contents and counters.
    always_comb begin
        rd_d     = rd_q;
        wdata_d  = wdata_q;
        wreg_d   = wreg_q;
        retire_d = retire_q;
        bubble_d = bubble_q;
        case (act)
            ACT_ZERO: begin
                rd_d    = '0;
                wdata_d = '0;
                wreg_d  = '0;
                if (bubble_q != '1) begin
                    bubble_d = CNT_W'(bubble_q + CNT_W'(1));
                end
            end
            ACT_CAPTURE: begin
                rd_d     = mem_rd;
                wdata_d  = mem_wdata;
                wreg_d   = wreg_san;
                retire_d = CNT_W'(retire_q + san_pop);
            end
            default: begin
            end
        endcase
        if (cnt_clr) begin
            retire_d = '0;
            bubble_d = '0;
        end
    end

    // State registers; reset clears everything, including held contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= '0;
            wdata_q  <= '0;
            wreg_q   <= '0;
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            wreg_q   <= wreg_d;
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    assign wb_rd      = rd_q;
    assign wb_wdata   = wdata_q;
    assign wb_wreg    = wreg_q;
    assign retire_cnt = retire_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register write-data width per lane.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width per lane.
REQ-003 The block SHALL have parameter LANES, default 2, number of parallel write-back lanes (1..4); lane 0 is oldest in program order.
REQ-004 The block SHALL have parameter STAGE, default 4, index of this stage in the stall vector.
REQ-005 The block SHALL have parameter CNT_W, default 32, performance counter width.
REQ-006 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port stall  input  6  pipeline stall vector, bit STAGE = this stage held, bit STAGE+1 = next stage held.
REQ-009 The block SHALL have port flush  input  1  discard the incoming group and insert a bubble.
REQ-010 The block SHALL have port cnt_clr  input  1  synchronous clear of both performance counters.
REQ-011 The block SHALL have port mem_rd  input  LANES*ADDR_W  packed per-lane destination addresses, lane 0 in LSBs.
REQ-012 The block SHALL have port mem_wdata  input  LANES*DATA_W  packed per-lane write data.
REQ-013 The block SHALL have port mem_wreg  input  LANES  per-lane write enable.
REQ-014 The block SHALL have port wb_rd  output  LANES*ADDR_W  registered destination addresses.
REQ-015 The block SHALL have port wb_wdata  output  LANES*DATA_W  registered write data.
REQ-016 The block SHALL have port wb_wreg  output  LANES  registered, sanitised write enables.
REQ-017 The block SHALL have port retire_cnt  output  CNT_W  count of lane writes captured, wraps modulo 2^CNT_W.
REQ-018 The block SHALL have port bubble_cnt  output  CNT_W  count of bubble cycles inserted, saturating at all-ones.

Function
REQ-019 Each rising edge SHALL select exactly one action, priority order: flush, bubble, hold, capture.
REQ-020 Flush (flush=1, any stall) SHALL load all outputs with zero address, zero data, wreg=0.
REQ-021 Bubble (stall[STAGE]=1, stall[STAGE+1]=0) SHALL load all outputs with zero address, zero data, wreg=0.
REQ-022 Hold (stall[STAGE]=1, stall[STAGE+1]=1) SHALL keep all outputs unchanged.
REQ-023 Capture (stall[STAGE]=0) SHALL load every lane's rd and wdata unconditionally and its sanitised wreg.
REQ-024 Sanitised wreg for lane i SHALL be 0 if mem_rd of lane i is zero.
REQ-025 Sanitised wreg for lane i SHALL be 0 if any younger lane j>i has mem_wreg=1 with equal nonzero mem_rd; else equal to mem_wreg[i].
REQ-026 Latency SHALL be one cycle from inputs to outputs on capture; no combinational input-to-output path.
REQ-027 On capture, retire_cnt SHALL increase by the population count of the sanitised wreg bits, wrapping.
REQ-028 On flush or bubble, bubble_cnt SHALL increase by 1, holding at all-ones once reached.
REQ-029 Hold cycles SHALL change neither counter.
REQ-030 cnt_clr=1 SHALL zero both counters on that edge, overriding any increment the same cycle; pipeline outputs are unaffected.
REQ-031 stall bits other than STAGE and STAGE+1 SHALL be ignored; STAGE=5 SHALL treat stall[STAGE+1] as 0.

Reset
REQ-032 rst=0 SHALL immediately, without clock, drive wb_rd=0, wb_wdata=0, wb_wreg=0, retire_cnt=0, bubble_cnt=0.
REQ-033 Reset asserted mid-hold SHALL discard held contents; first edge after release SHALL apply REQ-019 normally.

Verification
REQ-034 Capture: LANES=2, lane0 rd=3 wdata=0x11 wreg=1, lane1 rd=7 wdata=0x22 wreg=1, stall=0 -> next cycle wb_wreg=2'b11, wb_rd={7,3}, retire_cnt=2.
REQ-035 Conflict and x0: lane0 rd=9, lane1 rd=9, both wreg=1 -> wb_wreg=2'b10. Lane0 rd=0 wreg=1, lane1 wreg=0 -> wb_wreg=2'b00, retire_cnt unchanged.
REQ-036 Stall: stall=6'b010000 -> outputs zeroed, bubble_cnt+1. Then stall=6'b110000 for 3 cycles with changing inputs -> outputs and counters frozen.
REQ-037 Flush priority: flush=1 with stall=6'b110000 -> outputs zeroed, bubble_cnt+1.
REQ-038 Counters: preload bubble_cnt to all-ones via CNT_W=4 build and 16 bubbles -> stays 4'hF. Then cnt_clr=1 with a bubble the same cycle -> 0.
REQ-039 Async reset: assert rst=0 between clock edges during hold -> all outputs 0 before the next edge.
